// File: rtl/accum_seq_ctrl.sv
// accum_seq_ctrl: sequences one K-deep clear/fetch/flush/write accumulate pass per start pulse.
// Optional PERF_CNT_EN adds a cycle_count port reporting the length of the last completed pass.
module accum_seq_ctrl #(
    parameter int K_ACCUM_DEPTH = 64,
    parameter int ADDR_W        = (K_ACCUM_DEPTH > 1) ? $clog2(K_ACCUM_DEPTH) : 1,
    parameter int PIPE_LAT      = 2
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start_processing,
    output logic              processing_done,
    output logic              busy,
    output logic              sram_rd_en,
    output logic [ADDR_W-1:0] sram_rd_addr,
    output logic              mac_clear,
    output logic              mac_acc_en,
    output logic              result_wr_en
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]       cycle_count
`endif
);
    localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(K_ACCUM_DEPTH - 1);
    localparam logic [FW-1:0] LAST_FLUSH = FW'(PIPE_LAT - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FETCH, FLUSH, WRITE, DONE} state_t;

    state_t              state;
    logic [FW-1:0]       flush_cnt;
    logic [PIPE_LAT-1:0] delay_line;

    // mac_acc_en is the tail of the read-strobe delay line, so it stays a flop output
    assign mac_acc_en = delay_line[PIPE_LAT-1];

    always_ff @(posedge clk) begin
        if (srst) begin
            state           <= IDLE;
            flush_cnt       <= '0;
            delay_line      <= '0;
            processing_done <= 1'b0;
            busy            <= 1'b0;
            sram_rd_en      <= 1'b0;
            sram_rd_addr    <= '0;
            mac_clear       <= 1'b0;
            result_wr_en    <= 1'b0;
        end else begin
            delay_line <= PIPE_LAT'({delay_line, sram_rd_en});
            case (state)
                IDLE: begin
                    if (start_processing) begin
                        state     <= CLEAR;
                        busy      <= 1'b1;
                        mac_clear <= 1'b1;
                    end
                end
                CLEAR: begin
                    state        <= FETCH;
                    mac_clear    <= 1'b0;
                    sram_rd_en   <= 1'b1;
                    sram_rd_addr <= '0;
                end
                FETCH: begin
                    if (sram_rd_addr == LAST_ADDR) begin
                        state      <= FLUSH;
                        sram_rd_en <= 1'b0;
                        flush_cnt  <= '0;
                    end else begin
                        sram_rd_addr <= sram_rd_addr + ADDR_W'(1);
                    end
                end
                FLUSH: begin
                    if (flush_cnt == LAST_FLUSH) begin
                        state        <= WRITE;
                        result_wr_en <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                WRITE: begin
                    state           <= DONE;
                    result_wr_en    <= 1'b0;
                    processing_done <= 1'b1;
                end
                DONE: begin
                    state           <= IDLE;
                    processing_done <= 1'b0;
                    busy            <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] perf_cnt;

    // Latched on the WRITE->DONE edge so the DONE cycle already shows the full pass length
    always_ff @(posedge clk) begin
        if (srst) begin
            perf_cnt    <= '0;
            cycle_count <= '0;
        end else begin
            if (state == IDLE && start_processing) perf_cnt <= 32'd1;
            else if (state != IDLE) perf_cnt <= perf_cnt + 32'd1;
            if (state == WRITE) cycle_count <= perf_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_accum_seq_ctrl.sv
// tb_accum_seq_ctrl: directed bench for accum_seq_ctrl with a cycle-offset reference model.
// Runs a K=64/PIPE_LAT=2 instance and a K=1/PIPE_LAT=1 instance side by side; PERF_CNT_EN adds cycle_count checks.
module tb_accum_seq_ctrl;
    logic clk = 1'b0;
    logic srst = 1'b1;
    logic start = 1'b0;

    logic done0, busy0, rd0, clr0, acc0, wr0;
    logic [5:0] addr0;
    logic done1, busy1, rd1, clr1, acc1, wr1;
    logic [0:0] addr1;
`ifdef PERF_CNT_EN
    logic [31:0] cc0, cc1;
`endif

    accum_seq_ctrl u0 (
        .clk(clk), .srst(srst), .start_processing(start), .processing_done(done0), .busy(busy0),
        .sram_rd_en(rd0), .sram_rd_addr(addr0), .mac_clear(clr0), .mac_acc_en(acc0), .result_wr_en(wr0)
`ifdef PERF_CNT_EN
        , .cycle_count(cc0)
`endif
    );

    accum_seq_ctrl #(.K_ACCUM_DEPTH(1), .PIPE_LAT(1)) u1 (
        .clk(clk), .srst(srst), .start_processing(start), .processing_done(done1), .busy(busy1),
        .sram_rd_en(rd1), .sram_rd_addr(addr1), .mac_clear(clr1), .mac_acc_en(acc1), .result_wr_en(wr1)
`ifdef PERF_CNT_EN
        , .cycle_count(cc1)
`endif
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    bit chk_on = 1'b0;
    // Model state: cycle offset within the current pass (0 = idle), per the pass timing table
    int ph0 = 0, ph1 = 0;
    int cce0 = 0, cce1 = 0;

    int done_q0[$], done_q1[$], wr_q[$], clr_q[$];
    int rd_n, acc_n, busy_n, first_addr, last_addr, first_acc, last_acc;

    function automatic int nxt(int ph, bit rst, bit st, int k, int p);
        if (rst) return 0;
        if (ph == 0) return st ? 1 : 0;
        return (ph == k + 3 + p) ? 0 : ph + 1;
    endfunction

    always @(posedge clk) begin
        ph0 <= nxt(ph0, srst, start, 64, 2);
        ph1 <= nxt(ph1, srst, start, 1, 1);
        if (srst) cce0 <= 0;
        else if (nxt(ph0, srst, start, 64, 2) == 69) cce0 <= 69;
        if (srst) cce1 <= 0;
        else if (nxt(ph1, srst, start, 1, 1) == 5) cce1 <= 5;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp(input string tg, input int ph, input int k, input int p, input logic clr,
                       input logic rd, input logic [31:0] addr, input logic acc, input logic wr,
                       input logic dn, input logic bz);
        chk({tg, " mac_clear"}, 32'(clr), 32'(ph == 1));
        chk({tg, " sram_rd_en"}, 32'(rd), 32'(ph >= 2 && ph <= k + 1));
        if (ph >= 2 && ph <= k + 1) chk({tg, " sram_rd_addr"}, addr, 32'(ph - 2));
        chk({tg, " mac_acc_en"}, 32'(acc), 32'(ph >= 2 + p && ph <= k + 1 + p));
        chk({tg, " result_wr_en"}, 32'(wr), 32'(ph == k + 2 + p));
        chk({tg, " processing_done"}, 32'(dn), 32'(ph == k + 3 + p));
        chk({tg, " busy"}, 32'(bz), 32'(ph != 0));
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            cmp("k64", ph0, 64, 2, clr0, rd0, 32'(addr0), acc0, wr0, done0, busy0);
            cmp("k1", ph1, 1, 1, clr1, rd1, 32'(addr1), acc1, wr1, done1, busy1);
`ifdef PERF_CNT_EN
            chk("k64 cycle_count", cc0, 32'(cce0));
            chk("k1 cycle_count", cc1, 32'(cce1));
`endif
        end
    end

    function automatic bit st_pat(int mode, int n);
        case (mode)
            3: return n == 0 || n == 10 || n == 69 || n == 70;
            5: return n < 150;
            default: return n == 0;
        endcase
    endfunction

    // Cycle n of a run is the n-th cycle after the edge that samples a cycle-0 start
    task automatic run(input int mode, input int ncyc);
        done_q0.delete(); done_q1.delete(); wr_q.delete(); clr_q.delete();
        rd_n = 0; acc_n = 0; busy_n = 0;
        first_addr = -1; last_addr = -1; first_acc = -1; last_acc = -1;
        for (int n = 0; n <= ncyc; n++) begin
            @(posedge clk);
            #1;
            start = st_pat(mode, n);
            srst = (mode == 4 && n == 30);
            @(negedge clk);
            if (done0) done_q0.push_back(n);
            if (done1) done_q1.push_back(n);
            if (wr0) wr_q.push_back(n);
            if (clr0) clr_q.push_back(n);
            if (busy0) busy_n++;
            if (rd0) begin
                rd_n++;
                if (rd_n == 1) first_addr = int'(addr0);
                last_addr = int'(addr0);
            end
            if (acc0) begin
                acc_n++;
                if (acc_n == 1) first_acc = n;
                last_acc = n;
            end
            if (mode == 4 && n == 31) begin
                chk("t4 busy after srst", 32'(busy0), 0);
                chk("t4 acc_en after srst", 32'(acc0), 0);
            end
        end
        start = 1'b0;
        srst = 1'b0;
    endtask

    function automatic int qat(int q[$], int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    initial begin
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        srst = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1 busy", 32'(busy0), 0);
        chk("t1 outputs", 32'({done0, rd0, clr0, acc0, wr0}), 0);
`ifdef PERF_CNT_EN
        chk("t1 cycle_count", cc0, 0);
`endif

        run(2, 80);
        chk("t2 clear count", 32'(clr_q.size()), 1);
        chk("t2 clear cycle", 32'(qat(clr_q, 0)), 1);
        chk("t2 rd count", 32'(rd_n), 64);
        chk("t2 first addr", 32'(first_addr), 0);
        chk("t2 last addr", 32'(last_addr), 63);
        chk("t2 acc count", 32'(acc_n), 64);
        chk("t2 first acc", 32'(first_acc), 4);
        chk("t2 last acc", 32'(last_acc), 67);
        chk("t2 wr cycle", 32'(qat(wr_q, 0)), 68);
        chk("t2 done count", 32'(done_q0.size()), 1);
        chk("t2 done cycle", 32'(qat(done_q0, 0)), 69);
        chk("t2 busy cycles", 32'(busy_n), 69);
        chk("t6 k1 done cycle", 32'(qat(done_q1, 0)), 5);
`ifdef PERF_CNT_EN
        chk("t6 k64 cycle_count", cc0, 69);
        chk("t6 k1 cycle_count", cc1, 5);
`endif

        run(3, 145);
        chk("t3 done count", 32'(done_q0.size()), 2);
        chk("t3 first done", 32'(qat(done_q0, 0)), 69);
        chk("t3 second done", 32'(qat(done_q0, 1)), 139);

        run(4, 130);
        chk("t4 done count", 32'(done_q0.size()), 0);
        chk("t4 wr count", 32'(wr_q.size()), 0);
`ifdef PERF_CNT_EN
        chk("t4 cycle_count after srst", cc0, 0);
`endif

        run(5, 215);
        chk("t5 done count", 32'(done_q0.size()), 3);
        chk("t5 done 1", 32'(qat(done_q0, 0)), 69);
        chk("t5 done 2", 32'(qat(done_q0, 1)), 139);
        chk("t5 done 3", 32'(qat(done_q0, 2)), 209);
        chk("t5 wr count", 32'(wr_q.size()), 3);

        @(negedge clk);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
